// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider / tick generator with square-wave and tick
// outputs, pause/resume, one-shot mode and a glitch-free divide-value load.
`timescale 1ns/1ps

module prog_clk_div #(
    parameter int               DIV_W       = 32,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(300_000_000)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             oneshot,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    output logic             divided_clk,
    output logic             tick,
    output logic             div_busy,
    output logic             running,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic             busy;
    logic             cnt_at_end;
    logic             counting;
    logic             event_hit;
    logic             apply;

    // The edge leaving PAUSE also counts, so a pause of P cycles costs exactly P edges.
    assign cnt_at_end = (cnt == div_act - DIV_W'(1));
    assign counting   = en && ((state == ST_RUN) || (state == ST_PAUSE));
    assign event_hit  = counting && cnt_at_end;
    assign apply      = busy && (restart || event_hit || ((state == ST_IDLE) && en));

    assign div_busy = busy;
    assign running  = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    // A write on the applying edge lands after the apply and keeps busy set.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_act  <= DEFAULT_DIV;
            div_pend <= DEFAULT_DIV;
            busy     <= 1'b0;
        end else begin
            if (apply) begin
                div_act <= div_pend;
                busy    <= 1'b0;
            end
            if (div_wr) begin
                div_pend <= (div_in == '0) ? DIV_W'(1) : div_in;
                busy     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            divided_clk <= 1'b0;
            tick        <= 1'b0;
        end else if (restart) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            divided_clk <= 1'b0;
            tick        <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (!en) begin
                        state <= ST_PAUSE;
                    end else if (cnt_at_end) begin
                        cnt         <= '0;
                        divided_clk <= ~divided_clk;
                        tick        <= 1'b1;
                        state       <= oneshot ? ST_DONE : ST_RUN;
                    end else begin
                        cnt   <= cnt + DIV_W'(1);
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    cnt <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div: scenarios queue the expected tick edges and
// divided_clk levels, and a negedge monitor pops and compares on every tick.
`timescale 1ns/1ps

module tb_prog_clk_div;

    localparam int DIV_W = 16;

    typedef struct {
        int   edge_no;
        logic dclk;
    } tick_exp_t;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic             restart;
    logic             oneshot;
    logic             div_wr;
    logic [DIV_W-1:0] div_in;
    logic             divided_clk;
    logic             tick;
    logic             div_busy;
    logic             running;
    logic             done;

    int        n_checks = 0;
    int        n_errors = 0;
    int        edge_cnt = 0;
    int        e0;
    tick_exp_t exp_q[$];

    prog_clk_div #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(16'd4)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .oneshot    (oneshot),
        .div_wr     (div_wr),
        .div_in     (div_in),
        .divided_clk(divided_clk),
        .tick       (tick),
        .div_busy   (div_busy),
        .running    (running),
        .done       (done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d",
                     name, edge_cnt, actual, expected);
        end
    endtask

    task automatic expect_tick(input int edge_no, input logic dclk);
        tick_exp_t e;
        e.edge_no = edge_no;
        e.dclk    = dclk;
        exp_q.push_back(e);
    endtask

    task automatic check_queue(input string name);
        check_output(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic apply_stimulus(input logic en_v, input logic restart_v, input logic oneshot_v,
                                  input logic wr_v, input logic [DIV_W-1:0] din);
        en      = en_v;
        restart = restart_v;
        oneshot = oneshot_v;
        div_wr  = wr_v;
        div_in  = din;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk_in);
    endtask

    task automatic do_restart();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic write_div(input logic [DIV_W-1:0] v);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, v);
        step(1);
        check_output("busy_after_write", div_busy, 1);
        do_restart();
        check_output("busy_after_restart", div_busy, 0);
    endtask

    always @(negedge clk_in) begin
        tick_exp_t e;
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL unexpected_tick at edge %0d: got tick=1, expected tick=0", edge_cnt);
            end else begin
                e = exp_q.pop_front();
                check_output("tick_edge", edge_cnt, e.edge_no);
                check_output("tick_dclk", divided_clk, e.dclk);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(2);
        check_output("rst_tick", tick, 0);
        check_output("rst_dclk", divided_clk, 0);
        check_output("rst_busy", div_busy, 0);
        check_output("rst_running", running, 0);
        check_output("rst_done", done, 0);

        // Default divide of 4 straight out of reset
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        e0 = edge_cnt + 1;
        expect_tick(e0 + 4, 1'b1);
        expect_tick(e0 + 8, 1'b0);
        expect_tick(e0 + 12, 1'b1);
        wait_edge(e0);
        check_output("s1_running", running, 1);
        wait_edge(e0 + 13);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(2);
        check_output("s1_paused", running, 0);
        do_restart();
        check_output("s1_restart_dclk", divided_clk, 0);
        check_queue("s1_pending_ticks");

        // Reprogram 4 -> 2 mid-period; current period completes with old value
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        e0 = edge_cnt + 1;
        expect_tick(e0 + 4, 1'b1);
        expect_tick(e0 + 6, 1'b0);
        expect_tick(e0 + 8, 1'b1);
        wait_edge(e0 + 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
        step(1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_output("s2_busy_rise", div_busy, 1);
        wait_edge(e0 + 3);
        check_output("s2_busy_hold", div_busy, 1);
        wait_edge(e0 + 4);
        check_output("s2_busy_fall", div_busy, 0);
        wait_edge(e0 + 8);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1);
        do_restart();
        check_queue("s2_pending_ticks");

        // Pause for 3 cycles at cnt=2 with D=5
        write_div(16'd5);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        e0 = edge_cnt + 1;
        expect_tick(e0 + 8, 1'b1);
        expect_tick(e0 + 13, 1'b0);
        wait_edge(e0 + 2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1);
        check_output("s3_pause_running", running, 0);
        wait_edge(e0 + 5);
        check_output("s3_pause_hold", running, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1);
        check_output("s3_resume_running", running, 1);
        wait_edge(e0 + 13);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1);
        do_restart();
        check_queue("s3_pending_ticks");

        // One-shot with D=3
        write_div(16'd3);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
        e0 = edge_cnt + 1;
        expect_tick(e0 + 3, 1'b1);
        wait_edge(e0 + 3);
        check_output("s4_done", done, 1);
        check_output("s4_not_running", running, 0);
        wait_edge(e0 + 10);
        check_output("s4_done_hold", done, 1);
        check_output("s4_dclk_hold", divided_clk, 1);
        do_restart();
        check_output("s4_restart_done", done, 0);
        check_output("s4_restart_running", running, 0);
        check_output("s4_restart_dclk", divided_clk, 0);
        check_queue("s4_pending_ticks");

        // Zero write clamps to 1: tick every cycle
        write_div(16'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        e0 = edge_cnt + 1;
        for (int i = 1; i <= 6; i++) expect_tick(e0 + i, logic'(i % 2));
        wait_edge(e0 + 6);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1);
        check_output("s5_tick_low_paused", tick, 0);
        do_restart();
        check_queue("s5_pending_ticks");

        // Async reset mid-period restores DEFAULT_DIV
        write_div(16'd3);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        e0 = edge_cnt + 1;
        expect_tick(e0 + 3, 1'b1);
        wait_edge(e0 + 5);
        check_output("s6_pre_dclk", divided_clk, 1);
        #2 rst = 1'b1;
        #1;
        check_output("s6_async_dclk", divided_clk, 0);
        check_output("s6_async_tick", tick, 0);
        check_output("s6_async_running", running, 0);
        check_output("s6_async_done", done, 0);
        check_output("s6_async_busy", div_busy, 0);
        @(negedge clk_in);
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        e0 = edge_cnt + 1;
        expect_tick(e0 + 4, 1'b1);
        wait_edge(e0 + 4);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(2);
        check_queue("s6_pending_ticks");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
# prog_clk_div

Runtime-programmable clock divider / tick generator. It is the parametrised successor to the fixed-ratio game-timing dividers. It adds several features those dividers lack:
- a divide ratio that can be changed at runtime with a glitch-free load handshake;
- a simultaneous square-wave output and one-cycle tick output;
- pause/resume;
- one-shot mode.

Game-speed logic uses it to drive LED step rates that change as the level advances.

## Interface
- DIV_W, 32: width of divide value and counter.
- DEFAULT_DIV, 300_000_000: active divide value after reset. Must be ≥1.

- clk_in  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  level; count while high, pause while low.
- restart  in  1  synchronous pulse; clears count and phase, returns to IDLE.
- oneshot  in  1  level; when high, the block stops in DONE after the first event.
- div_wr  in  1  one-cycle write strobe for div_in.
- div_in  in  DIV_W  new divide value D.
- divided_clk  out  1  square wave, toggles on every event (period 2·D cycles).
- tick  out  1  one-cycle pulse per event.
- div_busy  out  1  a written value is pending and not yet active.
- running  out  1  state == RUN.
- done  out  1  state == DONE.

## Operation
- Registers:
  - cnt[DIV_W]
  - div_act[DIV_W]: active D
  - div_pend[DIV_W]
  - busy flag
  - 2-bit state
  - divided_clk
  - tick
- Event: the edge at which state==RUN, en==1 and cnt==div_act−1. On an event:
  - cnt<=0
  - divided_clk<=~divided_clk
  - tick<=1
  - if busy, then div_act<=div_pend and busy<=0
- Non-event edge in RUN with en=1: cnt<=cnt+1 and tick<=0. The counter never exceeds div_act−1.
- tick is 0 on every edge that is not an event.
- States and transitions (restart overrides all of them):
  - IDLE: cnt held 0. en=1 → RUN. If busy, apply the pending value on this edge.
  - RUN: en=0 → PAUSE (no count this edge). Event with oneshot=1 → DONE. Otherwise stay in RUN.
  - PAUSE: cnt, divided_clk and div_act are held. en=1 → RUN and resume from the held cnt. A pending value waits for the next event.
  - DONE: cnt=0 and divided_clk held. Only restart leaves DONE, going to IDLE.
- restart (any state): state<=IDLE, cnt<=0, divided_clk<=0, tick<=0. If busy, then div_act<=div_pend and busy<=0.
- Divide-value write: on div_wr, div_pend<=(div_in==0 ? 1 : div_in) and busy<=1.
  - A write while busy overwrites div_pend; busy stays high.
  - A write on the same edge as an apply: the old pending value is applied, then the new value is stored and busy stays 1.
- Priority: rst > restart > event/state logic. div_wr is independent of all three.
- D=1: an event occurs on every RUN edge, so tick stays high continuously and divided_clk toggles every cycle.

## Timing
- Reset values:
  - state=IDLE
  - cnt=0
  - div_act=DEFAULT_DIV
  - div_pend=DEFAULT_DIV
  - busy=0
  - divided_clk=0
  - tick=0
  - running=0
  - done=0
- All outputs are registered or decoded from state. Outputs change only after a clk_in edge or an rst assertion.
- en first sampled high at edge e0: IDLE→RUN at e0. The first event is at edge e0+D, and events then repeat every D edges while en stays high.
- Pausing for P cycles delays all later events by exactly P edges.
- A new D takes effect from the first period that starts after the applying edge. The current period always completes with the old D, so there are no runt pulses.
- div_busy rises the edge after div_wr and falls on the applying edge.

## Test plan
- Run with DEFAULT_DIV=4, en=1 from reset release: ticks at edges 4, 8, 12; divided_clk=1 after edge 4 and 0 after edge 8.
- D=4 running, div_wr with div_in=2 at cnt=1: busy high; next tick still at the old boundary; following ticks every 2 edges; busy falls on the first of them.
- Pause: D=5 running, en low for 3 cycles at cnt=2: cnt holds 2, running=0; the next tick is 3 edges later than unpaused.
- Oneshot: D=3, oneshot=1: exactly one tick at edge 3, then done=1 with no further ticks. restart → IDLE with done=0.
- div_in=0 write then restart: div_act=1, and tick stays high every cycle while running.
- Async rst mid-period (cnt=2, divided_clk=1): all outputs go to 0 immediately with no clock edge, and div_act returns to DEFAULT_DIV.
